// File: rtl/gen3_frame_parser.sv
`default_nettype none
// ============================================================================
// Module  : gen3_frame_parser
// Purpose : Gen3 receive framing parser, N_BYTES descrambled bytes per beat.
//           Tags every byte with a type code and flags framing errors.
// Rev     : 1.0  initial release
// ============================================================================
module gen3_frame_parser #(
  parameter int N_BYTES    = 4,
  parameter int LEN_W      = 11,
  parameter int MIN_TLP_DW = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic                   block_start_in,
  input  logic [1:0]             sync_header_in,
  input  logic [8*N_BYTES-1:0]   data_in,
  output logic                   valid_out,
  output logic [8*N_BYTES-1:0]   data_out,
  output logic [6*N_BYTES-1:0]   type_out,
  output logic                   framing_err,
  output logic                   tlp_done,
  output logic                   dllp_done
);

  localparam int REM_W = LEN_W + 2;

  localparam logic [5:0] C_T_NOT_VALID = 6'b000000;
  localparam logic [5:0] C_T_DATA      = 6'b100000;
  localparam logic [5:0] C_T_TLPSTART  = 6'b010000;
  localparam logic [5:0] C_T_TLPEND    = 6'b101000;
  localparam logic [5:0] C_T_DLLPSTART = 6'b000010;
  localparam logic [5:0] C_T_DLLPEND   = 6'b100100;
  localparam logic [5:0] C_T_TLPEDB    = 6'b000001;

  localparam logic [7:0] C_SDP_TOKEN1  = 8'hF0;
  localparam logic [7:0] C_SDP_TOKEN2  = 8'hAC;
  localparam logic [7:0] C_EDB_SYMBOL  = 8'hC0;
  localparam logic [1:0] C_SYNC_DATA   = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_STP1      = 3'd1,
    S_STP2      = 3'd2,
    S_STP3      = 3'd3,
    S_TLP_BODY  = 3'd4,
    S_SDP1      = 3'd5,
    S_DLLP_BODY = 3'd6
  } state_t;

  state_t             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [REM_W-1:0]   r_remaining;
  logic [2:0]         r_edb_run;
  logic               r_blk_is_data;

  state_t             w_state;
  logic [LEN_W-1:0]   w_len;
  logic [REM_W-1:0]   w_rem;
  logic [2:0]         w_edb;
  logic [2:0]         w_edb_nx;
  logic [7:0]         w_byte;
  logic               w_blk_is_data;
  logic [6*N_BYTES-1:0] w_type;
  logic               w_err;
  logic               w_tlp_done;
  logic               w_dllp_done;

  // Byte walk: each byte advances the framing state left by the byte before it.
  always_comb begin
    w_blk_is_data = r_blk_is_data;
    if (valid_in && block_start_in) begin
      w_blk_is_data = (sync_header_in == C_SYNC_DATA);
    end

    w_state     = r_state;
    w_len       = r_len;
    w_rem       = r_remaining;
    w_edb       = r_edb_run;
    w_edb_nx    = 3'd0;
    w_byte      = 8'h00;
    w_type      = '0;
    w_err       = 1'b0;
    w_tlp_done  = 1'b0;
    w_dllp_done = 1'b0;

    if (valid_in) begin
      if (!w_blk_is_data) begin
        if (r_state != S_IDLE) begin
          w_err   = 1'b1;
          w_state = S_IDLE;
          w_rem   = '0;
          w_edb   = 3'd0;
        end
      end else begin
        for (int i = 0; i < N_BYTES; i++) begin
          w_byte = data_in[8*i +: 8];
          w_type[6*i +: 6] = C_T_NOT_VALID;
          case (w_state)
            S_IDLE: begin
              if (w_byte == 8'h00) begin
                w_state = S_IDLE;
              end else if (w_byte[3:0] == 4'hF) begin
                w_len[3:0] = w_byte[7:4];
                w_state    = S_STP1;
              end else if (w_byte == C_SDP_TOKEN1) begin
                w_state = S_SDP1;
              end else begin
                w_err = 1'b1;
              end
            end
            S_STP1: begin
              w_len[LEN_W-1:4] = w_byte[LEN_W-5:0];
              w_state          = S_STP2;
            end
            S_STP2: begin
              w_state = S_STP3;
            end
            S_STP3: begin
              w_type[6*i +: 6] = C_T_TLPSTART;
              w_rem            = {w_len, 2'b00} - REM_W'(4);
              w_edb            = 3'd0;
              if (w_len < LEN_W'(MIN_TLP_DW)) begin
                w_err   = 1'b1;
                w_state = S_IDLE;
              end else begin
                w_state = S_TLP_BODY;
              end
            end
            S_TLP_BODY: begin
              if (w_byte == C_EDB_SYMBOL) begin
                w_edb_nx = (w_edb == 3'd7) ? 3'd7 : w_edb + 3'd1;
              end else begin
                w_edb_nx = 3'd0;
              end
              w_edb = w_edb_nx;
              if (w_rem > REM_W'(1)) begin
                w_type[6*i +: 6] = C_T_DATA;
                w_rem            = w_rem - REM_W'(1);
              end else begin
                // Four trailing EDB symbols mark the TLP as nullified.
                if (w_edb_nx >= 3'd4) begin
                  w_type[6*i +: 6] = C_T_TLPEDB;
                end else begin
                  w_type[6*i +: 6] = C_T_TLPEND;
                  w_tlp_done       = 1'b1;
                end
                w_rem   = '0;
                w_state = S_IDLE;
              end
            end
            S_SDP1: begin
              if (w_byte == C_SDP_TOKEN2) begin
                w_type[6*i +: 6] = C_T_DLLPSTART;
                w_rem            = REM_W'(6);
                w_state          = S_DLLP_BODY;
              end else begin
                w_err   = 1'b1;
                w_state = S_IDLE;
              end
            end
            S_DLLP_BODY: begin
              if (w_rem > REM_W'(1)) begin
                w_type[6*i +: 6] = C_T_DATA;
                w_rem            = w_rem - REM_W'(1);
              end else begin
                w_type[6*i +: 6] = C_T_DLLPEND;
                w_dllp_done      = 1'b1;
                w_rem            = '0;
                w_state          = S_IDLE;
              end
            end
            default: begin
              w_state = S_IDLE;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_remaining   <= '0;
      r_edb_run     <= 3'd0;
      r_blk_is_data <= 1'b0;
      valid_out     <= 1'b0;
      data_out      <= '0;
      type_out      <= '0;
      framing_err   <= 1'b0;
      tlp_done      <= 1'b0;
      dllp_done     <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_len         <= w_len;
      r_remaining   <= w_rem;
      r_edb_run     <= w_edb;
      r_blk_is_data <= w_blk_is_data;
      valid_out     <= valid_in;
      data_out      <= data_in;
      type_out      <= w_type;
      framing_err   <= w_err;
      tlp_done      <= w_tlp_done;
      dllp_done     <= w_dllp_done;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gen3_frame_parser.sv
`default_nettype none
// ============================================================================
// Module  : tb_gen3_frame_parser
// Purpose : Self-checking bench for gen3_frame_parser (N_BYTES = 4).
// Rev     : 1.0  initial release
// ============================================================================
module tb_gen3_frame_parser;

  localparam logic [5:0] T_NV  = 6'b000000;
  localparam logic [5:0] T_DAT = 6'b100000;
  localparam logic [5:0] T_TS  = 6'b010000;
  localparam logic [5:0] T_TE  = 6'b101000;
  localparam logic [5:0] T_DS  = 6'b000010;
  localparam logic [5:0] T_DE  = 6'b100100;
  localparam logic [5:0] T_EDB = 6'b000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        block_start_in;
  logic [1:0]  sync_header_in;
  logic [31:0] data_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [23:0] type_out;
  logic        framing_err;
  logic        tlp_done;
  logic        dllp_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] b;
    logic [5:0] t;
    logic       e;
    logic       tl;
    logic       dl;
  } exp_s;
  exp_s sq[$];

  gen3_frame_parser #(.N_BYTES(4), .LEN_W(11), .MIN_TLP_DW(5)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .block_start_in(block_start_in),
    .sync_header_in(sync_header_in), .data_in(data_in), .valid_out(valid_out),
    .data_out(data_out), .type_out(type_out), .framing_err(framing_err),
    .tlp_done(tlp_done), .dllp_done(dllp_done)
  );

  always #5 clk = ~clk;

  // Apply one beat, then sample 1 time unit after the capturing edge.
  task automatic drive(input logic v, input logic bs, input logic [1:0] sh, input logic [31:0] d);
    valid_in = v; block_start_in = bs; sync_header_in = sh; data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [27:0] exp;
    rst = 1'b0; valid_in = 1'b1; block_start_in = 1'b1; sync_header_in = 2'b01; data_in = 32'h1234565F;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done, data_out} !== 60'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, expected 0", {valid_out, type_out, framing_err, tlp_done, dllp_done, data_out});
    end
    rst = 1'b1;
    drive(1'b1, 1'b0, 2'b01, 32'h12345678);
    exp = {1'b1, T_NV, T_NV, T_NV, T_NV, 3'b000};
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== exp) begin
      n_fail++; $display("FAIL reset_blk_not_data: got %h, expected %h", {valid_out, type_out, framing_err, tlp_done, dllp_done}, exp);
    end
  endtask

  task automatic run_tlp(input string name, input logic [31:0] last_beat, input logic [23:0] last_type, input logic last_tlp);
    logic [27:0] exp;
    drive(1'b1, 1'b1, 2'b01, 32'h0000005F);
    exp = {1'b1, T_TS, T_NV, T_NV, T_NV, 3'b000};
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== exp) begin
      n_fail++; $display("FAIL %s_hdr: got %h, expected %h", name, {valid_out, type_out, framing_err, tlp_done, dllp_done}, exp);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 2'b01, (k == 3) ? last_beat : 32'h11111111);
      exp = (k == 3) ? {1'b1, last_type, 1'b0, last_tlp, 1'b0} : {1'b1, T_DAT, T_DAT, T_DAT, T_DAT, 3'b000};
      n_checks++;
      if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== exp) begin
        n_fail++; $display("FAIL %s_body%0d: got %h, expected %h", name, k, {valid_out, type_out, framing_err, tlp_done, dllp_done}, exp);
      end
    end
  endtask

  task automatic test_tlp();
    run_tlp("tlp", 32'h11111111, {T_TE, T_DAT, T_DAT, T_DAT}, 1'b1);
  endtask

  task automatic test_tlp_edb();
    run_tlp("tlp_edb", 32'hC0C0C0C0, {T_EDB, T_DAT, T_DAT, T_DAT}, 1'b0);
  endtask

  task automatic test_dllp();
    logic [27:0] exp;
    drive(1'b1, 1'b1, 2'b01, 32'h0201ACF0);
    exp = {1'b1, T_DAT, T_DAT, T_DS, T_NV, 3'b000};
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== exp) begin
      n_fail++; $display("FAIL dllp_start: got %h, expected %h", {valid_out, type_out, framing_err, tlp_done, dllp_done}, exp);
    end
    drive(1'b1, 1'b0, 2'b01, 32'h06050403);
    exp = {1'b1, T_DE, T_DAT, T_DAT, T_DAT, 3'b001};
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done, data_out} !== {exp, 32'h06050403}) begin
      n_fail++; $display("FAIL dllp_end: got %h, expected %h", {valid_out, type_out, framing_err, tlp_done, dllp_done, data_out}, {exp, 32'h06050403});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] beats [5];
    logic [27:0] exps  [5];
    beats = '{32'h01ACF000, 32'h05040302, 32'h07ACF006, 32'h0B0A0908, 32'h0000000C};
    exps  = '{{1'b1, T_DAT, T_DS, T_NV, T_NV, 3'b000},
              {1'b1, T_DAT, T_DAT, T_DAT, T_DAT, 3'b000},
              {1'b1, T_DAT, T_DS, T_NV, T_DE, 3'b001},
              {1'b1, T_DAT, T_DAT, T_DAT, T_DAT, 3'b000},
              {1'b1, T_NV, T_NV, T_NV, T_DE, 3'b001}};
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, k == 0, 2'b01, beats[k]);
      n_checks++;
      if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== exps[k]) begin
        n_fail++; $display("FAIL b2b_beat%0d: got %h, expected %h", k, {valid_out, type_out, framing_err, tlp_done, dllp_done}, exps[k]);
      end
    end
  endtask

  task automatic test_multi_err();
    drive(1'b1, 1'b1, 2'b01, 32'h12345678);
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== {1'b1, 24'd0, 3'b100}) begin
      n_fail++; $display("FAIL multi_err: got %h, expected %h", {valid_out, type_out, framing_err, tlp_done, dllp_done}, {1'b1, 24'd0, 3'b100});
    end
    drive(1'b1, 1'b0, 2'b01, 32'h00000000);
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== {1'b1, 24'd0, 3'b000}) begin
      n_fail++; $display("FAIL multi_err_pulse: got %h, expected %h", {valid_out, type_out, framing_err, tlp_done, dllp_done}, {1'b1, 24'd0, 3'b000});
    end
  endtask

  task automatic test_short_tlp();
    drive(1'b1, 1'b1, 2'b01, 32'h0000002F);
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== {1'b1, T_TS, T_NV, T_NV, T_NV, 3'b100}) begin
      n_fail++; $display("FAIL short_tlp: got %h, expected %h", {valid_out, type_out, framing_err, tlp_done, dllp_done}, {1'b1, T_TS, 18'd0, 3'b100});
    end
    drive(1'b1, 1'b0, 2'b01, 32'h00000000);
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== {1'b1, 24'd0, 3'b000}) begin
      n_fail++; $display("FAIL short_tlp_idle: got %h, expected %h", {valid_out, type_out, framing_err, tlp_done, dllp_done}, {1'b1, 24'd0, 3'b000});
    end
  endtask

  task automatic test_bubble();
    drive(1'b1, 1'b1, 2'b01, 32'h0201ACF0);
    drive(1'b0, 1'b0, 2'b01, $urandom);
    drive(1'b0, 1'b1, 2'b10, $urandom);
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== 28'd0) begin
      n_fail++; $display("FAIL bubble_outputs: got %h, expected 0", {valid_out, type_out, framing_err, tlp_done, dllp_done});
    end
    drive(1'b1, 1'b0, 2'b01, 32'h06050403);
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== {1'b1, T_DE, T_DAT, T_DAT, T_DAT, 3'b001}) begin
      n_fail++; $display("FAIL bubble_resume: got %h, expected %h", {valid_out, type_out, framing_err, tlp_done, dllp_done}, {1'b1, T_DE, T_DAT, T_DAT, T_DAT, 3'b001});
    end
  endtask

  task automatic test_os_abort();
    drive(1'b1, 1'b1, 2'b01, 32'h0000005F);
    drive(1'b1, 1'b0, 2'b01, 32'h11111111);
    drive(1'b1, 1'b1, 2'b10, $urandom);
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== {1'b1, 24'd0, 3'b100}) begin
      n_fail++; $display("FAIL os_abort: got %h, expected %h", {valid_out, type_out, framing_err, tlp_done, dllp_done}, {1'b1, 24'd0, 3'b100});
    end
    drive(1'b1, 1'b0, 2'b10, 32'h5FF01234);
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== {1'b1, 24'd0, 3'b000}) begin
      n_fail++; $display("FAIL os_idle: got %h, expected %h", {valid_out, type_out, framing_err, tlp_done, dllp_done}, {1'b1, 24'd0, 3'b000});
    end
    drive(1'b1, 1'b1, 2'b01, 32'h00000000);
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== {1'b1, 24'd0, 3'b000}) begin
      n_fail++; $display("FAIL os_then_data: got %h, expected %h", {valid_out, type_out, framing_err, tlp_done, dllp_done}, {1'b1, 24'd0, 3'b000});
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 2'b01, 32'h0000005F);
    drive(1'b1, 1'b0, 2'b01, 32'h11111111);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done, data_out} !== 60'd0) begin
      n_fail++; $display("FAIL async_reset: got %h, expected 0", {valid_out, type_out, framing_err, tlp_done, dllp_done, data_out});
    end
    @(posedge clk); #1 rst = 1'b1;
    drive(1'b1, 1'b1, 2'b01, 32'h0201ACF0);
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== {1'b1, T_DAT, T_DAT, T_DS, T_NV, 3'b000}) begin
      n_fail++; $display("FAIL post_reset_dllp: got %h, expected %h", {valid_out, type_out, framing_err, tlp_done, dllp_done}, {1'b1, T_DAT, T_DAT, T_DS, T_NV, 3'b000});
    end
    drive(1'b1, 1'b0, 2'b01, 32'h06050403);
    n_checks++;
    if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== {1'b1, T_DE, T_DAT, T_DAT, T_DAT, 3'b001}) begin
      n_fail++; $display("FAIL post_reset_dllp_end: got %h, expected %h", {valid_out, type_out, framing_err, tlp_done, dllp_done}, {1'b1, T_DE, T_DAT, T_DAT, T_DAT, 3'b001});
    end
  endtask

  // Reference model: packets are built from the framing rules and each byte
  // carries its expected tag, so expectations come from the generator itself.
  function automatic void push(input logic [7:0] b, input logic [5:0] t, input logic e, input logic tl, input logic dl);
    exp_s x;
    x.b = b; x.t = t; x.e = e; x.tl = tl; x.dl = dl;
    sq.push_back(x);
  endfunction

  task automatic gen_tlp(input int len, input bit force_edb);
    logic [10:0] l;
    logic [7:0]  body[$];
    int          n;
    bit          nullified;
    l = 11'(len);
    push({l[3:0], 4'hF}, T_NV, 1'b0, 1'b0, 1'b0);
    push({1'($urandom), l[10:4]}, T_NV, 1'b0, 1'b0, 1'b0);
    push(8'($urandom), T_NV, 1'b0, 1'b0, 1'b0);
    if (len < 5) begin
      push(8'($urandom), T_TS, 1'b1, 1'b0, 1'b0);
    end else begin
      push(8'($urandom), T_TS, 1'b0, 1'b0, 1'b0);
      n = 4 * len - 4;
      for (int k = 0; k < n; k++) body.push_back(($urandom_range(0, 2) == 0) ? 8'hC0 : 8'($urandom));
      if (force_edb) for (int k = n - 4; k < n; k++) body[k] = 8'hC0;
      nullified = (body[n-1] == 8'hC0) && (body[n-2] == 8'hC0) && (body[n-3] == 8'hC0) && (body[n-4] == 8'hC0);
      for (int k = 0; k < n - 1; k++) push(body[k], T_DAT, 1'b0, 1'b0, 1'b0);
      if (nullified) push(body[n-1], T_EDB, 1'b0, 1'b0, 1'b0);
      else           push(body[n-1], T_TE, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [7:0]  b;
    logic [31:0] d;
    logic [23:0] et;
    logic        ee, etl, edl, bs;
    bit          first;
    exp_s        x;
    int          kind;
    for (int p = 0; p < 250; p++) begin
      kind = $urandom_range(0, 99);
      if (kind < 15) begin
        push(8'h00, T_NV, 1'b0, 1'b0, 1'b0);
      end else if (kind < 50) begin
        gen_tlp($urandom_range(5, 40), $urandom_range(0, 3) == 0);
      end else if (kind < 75) begin
        push(8'hF0, T_NV, 1'b0, 1'b0, 1'b0);
        push(8'hAC, T_DS, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) push(8'($urandom), T_DAT, 1'b0, 1'b0, 1'b0);
        push(8'($urandom), T_DE, 1'b0, 1'b0, 1'b1);
      end else if (kind < 83) begin
        gen_tlp($urandom_range(0, 4), 1'b0);
      end else if (kind < 91) begin
        do b = 8'($urandom); while (b == 8'h00 || b[3:0] == 4'hF || b == 8'hF0);
        push(b, T_NV, 1'b1, 1'b0, 1'b0);
      end else begin
        push(8'hF0, T_NV, 1'b0, 1'b0, 1'b0);
        do b = 8'($urandom); while (b == 8'hAC);
        push(b, T_NV, 1'b1, 1'b0, 1'b0);
      end
    end
    while (sq.size() % 4 != 0) push(8'h00, T_NV, 1'b0, 1'b0, 1'b0);

    first = 1'b1;
    while (sq.size() > 0) begin
      if (!first && $urandom_range(0, 5) == 0) begin
        drive(1'b0, 1'($urandom), 2'($urandom), $urandom);
        n_checks++;
        if ({valid_out, type_out, framing_err, tlp_done, dllp_done} !== 28'd0) begin
          n_fail++; $display("FAIL rand_bubble: got %h, expected 0", {valid_out, type_out, framing_err, tlp_done, dllp_done});
        end
      end
      bs = first || ($urandom_range(0, 4) == 0);
      d = '0; et = '0; ee = 1'b0; etl = 1'b0; edl = 1'b0;
      for (int i = 0; i < 4; i++) begin
        x = sq.pop_front();
        d[8*i +: 8]  = x.b;
        et[6*i +: 6] = x.t;
        ee  = ee | x.e;
        etl = etl | x.tl;
        edl = edl | x.dl;
      end
      drive(1'b1, bs, 2'b01, d);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== d) begin
        n_fail++; $display("FAIL rand_data: got valid=%b data=%h, expected valid=1 data=%h", valid_out, data_out, d);
      end
      n_checks++;
      if (type_out !== et) begin
        n_fail++; $display("FAIL rand_type: got %h, expected %h (data %h)", type_out, et, d);
      end
      n_checks++;
      if ({framing_err, tlp_done, dllp_done} !== {ee, etl, edl}) begin
        n_fail++; $display("FAIL rand_flags: got err/tlp/dllp=%b, expected %b (data %h)", {framing_err, tlp_done, dllp_done}, {ee, etl, edl}, d);
      end
      first = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tlp();
    test_tlp_edb();
    test_dllp();
    test_back_to_back();
    test_multi_err();
    test_short_tlp();
    test_bubble();
    test_os_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
